// File: rtl/debounce_tick_fsm.sv
// Tick-qualified switch debouncer: a level change is accepted after N_TICKS upstream ticks of stable input.
// Define DEBOUNCE_SYNC_EN to route sw through a two-flop synchroniser.
module debounce_tick_fsm #(
  parameter int N_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall,
  output logic busy
);

  localparam int CW = $clog2(N_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_TICKS - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_INC  = CW'(1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_level_q, db_level_d;
  logic          db_rise_q, db_rise_d;
  logic          db_fall_q, db_fall_d;
  logic          busy_q, busy_d;
  logic          sw_s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign sw_s = sync2_q;
`else
  assign sw_s = sw;
`endif

  // A return to the accepted level always wins over a tick in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        if (sw_s) begin
          state_d = WAIT1;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ZERO;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_d = ZERO;
          cnt_d   = CNT_ZERO;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ONE;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_INC;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_d = WAIT0;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ONE;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_d = ONE;
          cnt_d   = CNT_ZERO;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ZERO;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q + CNT_INC;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ZERO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    db_level_d = (state_d == ONE) || (state_d == WAIT0);
    busy_d     = (state_d == WAIT1) || (state_d == WAIT0);
    db_rise_d  = (state_q == WAIT1) && (state_d == ONE);
    db_fall_d  = (state_q == WAIT0) && (state_d == ZERO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ZERO;
      cnt_q      <= CNT_ZERO;
      db_level_q <= 1'b0;
      db_rise_q  <= 1'b0;
      db_fall_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= db_level_d;
      db_rise_q  <= db_rise_d;
      db_fall_q  <= db_fall_d;
      busy_q     <= busy_d;
    end
  end

  assign db_level = db_level_q;
  assign db_rise  = db_rise_q;
  assign db_fall  = db_fall_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_debounce_tick_fsm.sv
// Randomized bench for debounce_tick_fsm against a level/run-length reference model.
module tb_debounce_tick_fsm;

  localparam int N = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  logic reset, tick, sw;
  logic db_level, db_rise, db_fall, busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: accepted level, whether a differing input is pending,
  // and how many ticks the differing input has survived.
  bit m_level, m_pend, m_rise, m_fall;
  int m_run;
  bit h1, h2;
  int tcnt = 0;

  debounce_tick_fsm #(.N_TICKS(N)) dut (
    .clk(clk), .reset(reset), .tick(tick), .sw(sw),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic s);
    bit sws;
    reset = r;
    tick  = t;
    sw    = s;
    @(posedge clk);
    sws = (DLY == 0) ? s : h2;
    if (r) begin
      m_level = 1'b0; m_pend = 1'b0; m_run = 0;
      m_rise = 1'b0; m_fall = 1'b0;
      h1 = 1'b0; h2 = 1'b0;
    end else begin
      h2 = h1;
      h1 = s;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (sws == m_level) begin
        m_pend = 1'b0;
        m_run  = 0;
      end else if (!m_pend) begin
        m_pend = 1'b1;
        m_run  = 0;
      end else if (t) begin
        m_run++;
        if (m_run == N) begin
          m_level = ~m_level;
          m_rise  = m_level;
          m_fall  = ~m_level;
          m_pend  = 1'b0;
          m_run   = 0;
        end
      end
    end
    #1;
    chk("db_level", db_level, m_level);
    chk("busy", busy, m_pend);
    chk("db_rise", db_rise, m_rise);
    chk("db_fall", db_fall, m_fall);
  endtask

  function automatic logic gen_tick(input int mode);
    tcnt++;
    case (mode)
      0:       return (tcnt % 10) == 9;
      1:       return ($urandom_range(0, 99) < 30);
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    reset = 1'b1; tick = 1'b0; sw = 1'b1;
    m_level = 1'b0; m_pend = 1'b0; m_run = 0;
    m_rise = 1'b0; m_fall = 1'b0; h1 = 1'b0; h2 = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, gen_tick(0), 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, gen_tick(0), 1'b1);
    for (int i = 0; i < 60; i++) step(1'b0, gen_tick(0), 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, gen_tick(0), 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, gen_tick(0), 1'b0);

    for (int seg = 0; seg < 150; seg++) begin
      int len, mode;
      logic lvl;
      len  = $urandom_range(1, 50);
      mode = $urandom_range(0, 2);
      lvl  = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        logic r, s;
        r = ($urandom_range(0, 199) == 0);
        s = ($urandom_range(0, 39) == 0) ? ~lvl : lvl;
        step(r, gen_tick(mode), s);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
